// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates one shared word memory between an instruction cache and a data cache
//
// Purpose: single-port memory arbiter. The data cache issues single-word
// reads/writes and the instruction cache issues 4-word block fills. Ties are
// broken round-robin (FIXED_PRIO=0) or always in favour of the data cache
// (FIXED_PRIO=1).
//
// Ports:
//   CLK, RESET                clock; asynchronous active-high reset
//   IC_READ, IC_ADDRESS       instruction block-fill request, 16-byte block address
//   IC_READDATA, IC_BUSYWAIT  filled block (word k at [32k+31:32k]), instruction stall
//   DC_READ, DC_WRITE         data word read/write request
//   DC_ADDRESS, DC_WRITEDATA  data word address and write word
//   DC_READDATA, DC_BUSYWAIT  read word, data stall
//   MEM_READ, MEM_WRITE       shared memory strobes
//   MEM_ADDRESS, MEM_WRITEDATA memory word address and write word
//   MEM_READDATA, MEM_BUSYWAIT memory read word and stall
module mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IC_READ,
  input  logic [5:0]   IC_ADDRESS,
  output logic [127:0] IC_READDATA,
  output logic         IC_BUSYWAIT,
  input  logic         DC_READ,
  input  logic         DC_WRITE,
  input  logic [7:0]   DC_ADDRESS,
  input  logic [31:0]  DC_WRITEDATA,
  output logic [31:0]  DC_READDATA,
  output logic         DC_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [7:0]   MEM_ADDRESS,
  output logic [31:0]  MEM_WRITEDATA,
  input  logic [31:0]  MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DC_RD   = 3'd1;
  localparam logic [2:0] DC_WR   = 3'd2;
  localparam logic [2:0] IC_FILL = 3'd3;
  localparam logic [2:0] DONE_DC = 3'd4;
  localparam logic [2:0] DONE_IC = 3'd5;

  logic [2:0] state;
  logic       last_dc;   // 1 when the data cache received the most recent grant
  logic [1:0] beat;
  logic       gap;       // idle cycle between fill beats
  logic       dc_req;
  logic       ic_req;
  logic       grant_dc;
  logic       dc_active;

  assign dc_req    = DC_READ | DC_WRITE;
  assign ic_req    = IC_READ;
  assign dc_active = (state == DC_RD) || (state == DC_WR);

  // DC wins when alone, when prioritised, or when IC held the last grant.
  assign grant_dc = dc_req && (!ic_req || (FIXED_PRIO != 0) || !last_dc);

  assign MEM_READ      = (state == DC_RD) || ((state == IC_FILL) && !gap);
  assign MEM_WRITE     = (state == DC_WR);
  assign MEM_ADDRESS   = dc_active ? DC_ADDRESS :
                         (state == IC_FILL) ? {IC_ADDRESS, beat} : 8'd0;
  assign MEM_WRITEDATA = dc_active ? DC_WRITEDATA : 32'd0;

  // A requester stalls until its own DONE cycle, including while the other side owns memory.
  assign IC_BUSYWAIT = !RESET && ic_req && (state != DONE_IC);
  assign DC_BUSYWAIT = !RESET && dc_req && (state != DONE_DC);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      last_dc     <= 1'b0;
      beat        <= 2'd0;
      gap         <= 1'b0;
      IC_READDATA <= 128'd0;
      DC_READDATA <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dc) begin
            state   <= DC_WRITE ? DC_WR : DC_RD;
            last_dc <= 1'b1;
          end else if (ic_req) begin
            state   <= IC_FILL;
            beat    <= 2'd0;
            gap     <= 1'b0;
            last_dc <= 1'b0;
          end
        end
        DC_RD: begin
          if (!MEM_BUSYWAIT) begin
            DC_READDATA <= MEM_READDATA;
            state       <= DONE_DC;
          end
        end
        DC_WR: begin
          if (!MEM_BUSYWAIT) begin
            state <= DONE_DC;
          end
        end
        IC_FILL: begin
          if (gap) begin
            gap <= 1'b0;
          end else if (!MEM_BUSYWAIT) begin
            IC_READDATA[{beat, 5'd0} +: 32] <= MEM_READDATA;
            if (beat == 2'd3) begin
              state <= DONE_IC;
            end else begin
              beat <= beat + 2'd1;
              gap  <= 1'b1;
            end
          end
        end
        DONE_DC, DONE_IC: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule
